// File: rtl/count_uart_tx_pkg.sv
// count_uart_tx shared types and constants.
// 8N1 frame levels and FSM encoding.
package count_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/count_uart_tx_if.sv
// count_uart_tx data/status bundle.
// master drives count and request, slave drives the line.
interface count_uart_tx_if;

    logic [7:0] count_in;
    logic       send_req;
    logic       tx;
    logic       busy;
    logic       sent;
    logic       dropped;

    modport master (
        output count_in, send_req,
        input  tx, busy, sent, dropped
    );

    modport slave (
        input  count_in, send_req,
        output tx, busy, sent, dropped
    );

endinterface

// File: rtl/count_uart_tx_baud_tick_gen.sv
// Bit-period divider: one tick every CLK_DIV enabled cycles.
// Kept standalone so a receiver can share it.
module baud_tick_gen #(
    parameter int CLK_DIV = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Wrapping count, held at zero while clr is asserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            if (clr || cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign tick = ena & (cnt == LAST);

endmodule

// File: rtl/count_uart_tx.sv
// Serialises the counter value as an 8N1 UART frame.
// Explicit request or optional auto-send when the count changes.
module count_uart_tx
    import count_uart_pkg::*;
#(
    parameter int CLK_DIV        = 104,
    parameter bit SEND_ON_CHANGE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    count_uart_tx_if.slave bus
);

    localparam int IW = $clog2(DATA_BITS);

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] last_sent;
    logic [IW-1:0]        bit_idx;
    logic                 pending;
    logic                 tick;
    logic                 trig;
    logic                 idle;
    logic                 frame_go;
    logic                 last_bit;
    logic                 tx_d;
    logic                 busy_d;
    logic                 sent_d;

    assign idle     = (state == IDLE);
    assign trig     = bus.send_req
                    | (SEND_ON_CHANGE & (bus.count_in != last_sent));
    assign frame_go = idle & (trig | pending);
    assign last_bit = (bit_idx == IW'(DATA_BITS - 1));

    baud_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (idle),
        .tick  (tick)
    );

    // State register; ena=0 freezes the frame in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Next state: each phase advances on the bit boundary tick.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (trig || pending)      state_nxt = START;
            START:   if (tick)                 state_nxt = DATA;
            DATA:    if (tick && last_bit)     state_nxt = STOP;
            STOP:    if (tick)                 state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Line level and status decoded from the current phase.
    always_comb begin
        tx_d   = IDLE_LVL;
        busy_d = 1'b1;
        sent_d = 1'b0;
        unique case (state)
            IDLE:  busy_d = 1'b0;
            START: tx_d   = START_LVL;
            DATA:  tx_d   = shift_q[0];
            STOP: begin
                tx_d   = STOP_LVL;
                sent_d = tick;
            end
            default: busy_d = 1'b0;
        endcase
    end

    // Data capture at frame start, LSB-first shifting, one-deep pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q   <= '0;
            last_sent <= '0;
            bit_idx   <= '0;
            pending   <= 1'b0;
        end else if (ena) begin
            if (frame_go) begin
                shift_q   <= bus.count_in;
                last_sent <= bus.count_in;
                pending   <= 1'b0;
            end else if (!idle && trig) begin
                pending <= 1'b1;
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && tick) begin
                shift_q <= shift_q >> 1;
                bit_idx <= bit_idx + IW'(1);
            end
        end
    end

    assign bus.tx      = tx_d;
    assign bus.busy    = busy_d;
    assign bus.sent    = sent_d;
    assign bus.dropped = ena & ~idle & bus.send_req & pending;

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx: two instances (request-only and auto-send).
// Frame-level reference model feeds a scoreboard drained by a line decoder.
module tb_count_uart_tx;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;
    localparam bit [1:0] SOC = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] req;
    logic [7:0] cnt [2];
    logic [1:0] tx_o, busy_o, sent_o, drop_o;
    bit         chk_on = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    count_uart_tx_if if0 ();
    count_uart_tx_if if1 ();

    assign if0.count_in = cnt[0];
    assign if0.send_req = req[0];
    assign if1.count_in = cnt[1];
    assign if1.send_req = req[1];
    assign tx_o   = {if1.tx, if0.tx};
    assign busy_o = {if1.busy, if0.busy};
    assign sent_o = {if1.sent, if0.sent};
    assign drop_o = {if1.dropped, if0.dropped};

    count_uart_tx #(.CLK_DIV(DIV), .SEND_ON_CHANGE(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (if0)
    );

    count_uart_tx #(.CLK_DIV(DIV), .SEND_ON_CHANGE(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (if1)
    );

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: remaining-cycle countdown per frame, one pending slot.
    int         m_rem  [2];
    bit         m_pend [2];
    logic [7:0] m_last [2];
    logic [7:0] m_byte [2];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_rem[d]  = 0;
            m_pend[d] = 0;
            m_last[d] = 0;
            m_byte[d] = 0;
        end
    end

    always @(posedge clk) begin
        bit t;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_rem[d]  = 0;
                m_pend[d] = 0;
                m_last[d] = 0;
            end else if (ena) begin
                t = req[d] || (SOC[d] && cnt[d] != m_last[d]);
                if (m_rem[d] == 0) begin
                    if (t || m_pend[d]) begin
                        m_byte[d] = cnt[d];
                        m_last[d] = cnt[d];
                        m_pend[d] = 0;
                        m_rem[d]  = FRAME;
                        if (d == 0) exp_q0.push_back(cnt[d]);
                        else        exp_q1.push_back(cnt[d]);
                    end
                end else begin
                    if (t) m_pend[d] = 1;
                    m_rem[d]--;
                end
            end
        end
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
        end
    end

    function automatic logic exp_tx(int rem, logic [7:0] b);
        int pos;
        if (rem == 0) return 1'b1;
        pos = FRAME - rem;
        if (pos < DIV) return 1'b0;
        if (pos < 9 * DIV) return b[(pos - DIV) / DIV];
        return 1'b1;
    endfunction

    // Cycle-level comparison of line and status against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("tx%0d", d), int'(tx_o[d]),
                    int'(exp_tx(m_rem[d], m_byte[d])));
                chk($sformatf("busy%0d", d), int'(busy_o[d]),
                    int'(m_rem[d] != 0));
                chk($sformatf("sent%0d", d), int'(sent_o[d]),
                    int'(ena && m_rem[d] == 1));
                chk($sformatf("dropped%0d", d), int'(drop_o[d]),
                    int'(ena && m_rem[d] != 0 && req[d] && m_pend[d]));
            end
        end
    end

    // Line decoder: samples mid-bit, pops the scoreboard on each sent pulse.
    int         mon_idx  [2];
    logic [9:0] mon_bits [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            mon_idx[d]  = 0;
            mon_bits[d] = '0;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                if (!busy_o[d]) begin
                    mon_idx[d] = 0;
                end else begin
                    if (mon_idx[d] % DIV == DIV / 2 && mon_idx[d] / DIV < 10)
                        mon_bits[d][mon_idx[d] / DIV] = tx_o[d];
                    if (sent_o[d]) begin
                        if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                            chk($sformatf("unexpected_frame%0d", d), 1, 0);
                        end else begin
                            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            chk($sformatf("frame_byte%0d", d),
                                int'(mon_bits[d][8:1]), int'(e));
                            chk($sformatf("start_bit%0d", d), int'(mon_bits[d][0]), 0);
                            chk($sformatf("stop_bit%0d", d), int'(mon_bits[d][9]), 1);
                        end
                    end
                    if (ena) mon_idx[d]++;
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_req(int d, logic [7:0] v);
        cnt[d] = v;
        req[d] = 1'b1;
        cyc(1);
        req[d] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy, sent_at, ndrop, drop_at;
        logic b41, b42, tx14, tx21;

        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = '0;
        cnt[0] = 8'h00;
        cnt[1] = 8'h00;
        cyc(1);
        chk_on = 1'b1;
        cyc(2);
        chk("rst_tx", int'(tx_o), 3);
        chk("rst_busy", int'(busy_o), 0);
        rst_n = 1'b1;

        nbusy = 0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (busy_o != 0) nbusy++;
            cyc(1);
        end
        chk("idle_no_frame", nbusy, 0);

        pulse_req(0, 8'hA5);
        nbusy = 0;
        sent_at = -1;
        for (int k = 1; k <= 45; k++) begin
            #1;
            nbusy += int'(busy_o[0]);
            if (sent_o[0]) sent_at = k;
            if (k == 1) chk("basic_start_latency", int'(tx_o[0]), 0);
            cyc(1);
        end
        chk("basic_busy_len", nbusy, FRAME);
        chk("basic_sent_at", sent_at, FRAME);

        cnt[1] = 8'h03;
        cyc(1);
        sent_at = -1;
        nbusy = 0;
        for (int k = 1; k <= 75; k++) begin
            #1;
            if (sent_o[1]) sent_at = k;
            if (k > FRAME) nbusy += int'(busy_o[1]);
            cyc(1);
        end
        chk("auto_sent_at", sent_at, FRAME);
        chk("auto_then_idle", nbusy, 0);

        pulse_req(0, 8'h11);
        ndrop = 0;
        drop_at = -1;
        b41 = 1'b1;
        b42 = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            req[0] = (k == 5 || k == 10);
            if (k == 20) cnt[0] = 8'h7E;
            #1;
            if (drop_o[0]) begin
                ndrop++;
                drop_at = k;
            end
            if (k == 41) b41 = busy_o[0];
            if (k == 42) b42 = busy_o[0];
            cyc(1);
        end
        req[0] = 1'b0;
        chk("drop_count", ndrop, 1);
        chk("drop_at", drop_at, 10);
        chk("gap_idle", int'(b41), 0);
        chk("second_start", int'(b42), 1);

        pulse_req(0, 8'h5A);
        sent_at = -1;
        tx14 = 1'b0;
        tx21 = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            ena = !(k >= 14 && k < 21);
            #1;
            if (k == 14) tx14 = tx_o[0];
            if (k == 21) tx21 = tx_o[0];
            if (sent_o[0]) sent_at = k;
            cyc(1);
        end
        ena = 1'b1;
        chk("ena_tx_frozen", int'(tx21), int'(tx14));
        chk("ena_sent_late", sent_at, FRAME + 7);

        pulse_req(0, 8'hC3);
        cyc(17);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        #1;
        chk("midrst_tx", int'(tx_o[0]), 1);
        chk("midrst_busy", int'(busy_o[0]), 0);
        cyc(1);
        pulse_req(0, 8'hC3);
        sent_at = -1;
        for (int k = 1; k <= 45; k++) begin
            #1;
            if (sent_o[0]) sent_at = k;
            cyc(1);
        end
        chk("after_rst_sent_at", sent_at, FRAME);

        for (int k = 0; k < 2000; k++) begin
            rst_n  = ($urandom % 800) != 0;
            ena    = ($urandom % 8) != 0;
            req[0] = ($urandom % 29) == 0;
            req[1] = ($urandom % 37) == 0;
            if ($urandom % 50 == 0) cnt[0] = 8'($urandom);
            if ($urandom % 60 == 0) cnt[1] = 8'($urandom);
            cyc(1);
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        req   = '0;
        cyc(4 * FRAME);

        chk("drain_q0", exp_q0.size(), 0);
        chk("drain_q1", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
